ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared open-collector ps2_clk/ps2_data lines. The device generates the clock; this block inhibits the bus, issues the start condition, shifts data, parity and stop on device clock falls, and checks the device acknowledge. It sits beside the PS/2 receive path in the SoC top level, and its busy output gates that receiver while a frame is in flight.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit and receive paths:
// FSM states, frame length, common command bytes and the parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } ps2_tx_state_e;

  localparam int PS2_FRAME_EDGES = 11;
  localparam int PS2_DATA_BITS   = 8;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins, plus a falling-edge
// strobe on the clock line. Shared by the host transmit and receive paths.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [2:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
  end

  // Idle bus is pulled high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues the start bit,
// shifts one command byte on device clock falls and reports the acknowledge.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | lines released, tx_ready high, waiting for a byte
// ST_INHIBIT   | clock held low; start bit driven in the last cycle
// ST_RELEASE   | clock released, start bit held, waiting for first fall
// ST_SHIFT     | data, parity, stop driven on falls; ack sampled on 11th
// ST_WAIT_IDLE | waiting for device to release both lines, then done
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int unsigned INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0]  INH_LOAD  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] EDGE_PARITY = 4'(PS2_DATA_BITS + 1);
  localparam logic [3:0] EDGE_STOP   = 4'(PS2_DATA_BITS + 2);
  localparam logic [3:0] EDGE_ACK    = 4'(PS2_FRAME_EDGES);

  logic clk_s, data_s, fall;

  ps2_line_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .fall       (fall)
  );

  ps2_tx_state_e     state_q, state_d;
  logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [3:0]        edge_cnt_q, edge_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              clk_oe_q, clk_oe_d;
  logic              data_oe_q, data_oe_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_ok_q, ack_ok_d;
  logic              err_q, err_d;

  logic       accept;
  logic       timeout;
  logic [3:0] edge_nxt;

  assign accept   = tx_valid && tx_ready_q;
  assign timeout  = (wdog_q == '0) && !fall;
  assign edge_nxt = edge_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    edge_cnt_d = edge_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (accept) begin
          state_d   = ST_INHIBIT;
          shift_d   = tx_data;
          parity_d  = ps2_odd_parity(tx_data);
          ack_ok_d  = 1'b0;
          inh_cnt_d = INH_LOAD;
          clk_oe_d  = 1'b1;
          data_oe_d = (INH_LOAD == '0);
        end
      end

      // Down-counter: start bit goes out one cycle before the clock is released.
      ST_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          state_d    = ST_RELEASE;
          clk_oe_d   = 1'b0;
          edge_cnt_d = '0;
        end else begin
          inh_cnt_d = inh_cnt_q - INH_W'(1);
          if (inh_cnt_q == INH_W'(1)) data_oe_d = 1'b1;
        end
      end

      ST_RELEASE, ST_SHIFT: begin
        if (fall) begin
          state_d    = ST_SHIFT;
          edge_cnt_d = edge_nxt;
          if (edge_nxt <= 4'(PS2_DATA_BITS)) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (edge_nxt == EDGE_PARITY) begin
            data_oe_d = ~parity_q;
          end else if (edge_nxt == EDGE_STOP) begin
            data_oe_d = 1'b0;
          end else if (edge_nxt == EDGE_ACK) begin
            ack_ok_d = ~data_s;
            state_d  = ST_WAIT_IDLE;
          end
        end else if (timeout) begin
          state_d   = ST_IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (timeout) begin
          state_d   = ST_IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase

    // Watchdog restarts on every device clock fall and every state change.
    if (state_d != state_q || fall) wdog_d = WDOG_LOAD;
    else if (wdog_q != '0)          wdog_d = wdog_q - WDOG_W'(1);
    else                            wdog_d = wdog_q;

    // Keep busy through the done cycle so the next accept lands one cycle later.
    tx_ready_d = (state_d == ST_IDLE) && !done_d;
    busy_d     = !tx_ready_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inh_cnt_q  <= '0;
      wdog_q     <= WDOG_LOAD;
      edge_cnt_q <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      wdog_q     <= wdog_d;
      edge_cnt_q <= edge_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      err_q      <= err_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on a wired-AND bus plus a
// scoreboard that checks each frame ending (done or err) against a queue.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 40;
  localparam int TO  = 3000;
  localparam int H   = 30;

  logic       clk, reset;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, err;
  logic       dev_clk, dev_data;

  assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       ack;
    logic       is_err;
  } exp_t;

  exp_t       exp_q[$];
  int         n_run  = 0;
  int         n_fail = 0;
  logic [7:0] rx_byte;
  logic       rx_par, rx_stop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_run++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every frame ending is matched against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (done || err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_end", {30'd0, done, err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("end_err", err, e.is_err);
        chk("end_done", done, !e.is_err);
        if (e.is_err) begin
          chk("err_clk_oe", ps2_clk_oe, 0);
          chk("err_data_oe", ps2_data_oe, 0);
          chk("err_tx_ready", tx_ready, 1);
        end else begin
          chk("rx_byte", rx_byte, e.data);
          chk("rx_parity", rx_par, e.par);
          chk("rx_stop", rx_stop, 1);
          chk("ack_ok", ack_ok, e.ack);
          chk("done_tx_ready", tx_ready, 0);
          chk("done_busy", busy, 1);
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!tx_ready && w < 2000) begin w++; @(negedge clk); end
    chk("tx_ready_wait", tx_ready, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic ack,
                      input logic is_err, input logic push, input logic hold);
    wait_ready();
    if (push) exp_q.push_back('{data: d, par: par, ack: ack, is_err: is_err});
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    chk("accept_clk_oe", ps2_clk_oe, 1);
    chk("accept_busy", busy, 1);
  endtask

  // Device model; entered on the first cycle the host holds the clock low.
  task automatic device(input int edges, input logic ack_low);
    int n = 0;
    int dn = 0;
    while (ps2_clk_oe && n < INH + 100) begin
      n++;
      if (ps2_data_oe) dn++;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    chk("inhibit_start_cycles", dn, 1);
    chk("start_bit_pin", ps2_data_i, 0);
    for (int k = 1; k <= edges; k++) begin
      repeat (H) @(negedge clk);
      if (k == 11 && ack_low) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (k <= 8)       rx_byte[k-1] = ps2_data_i;
      else if (k == 9)  rx_par       = ps2_data_i;
      else if (k == 10) rx_stop      = ps2_data_i;
      dev_clk = 1'b1;
    end
    if (edges == 11) begin
      repeat (H) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  initial begin : global_guard
    #2000000;
    $display("FAIL global_time_limit: simulation did not reach its end");
    $fatal(1, "time limit");
  end

  typedef struct packed {
    logic [7:0] d;
    logic       par;
  } vec_t;

  initial begin : main
    vec_t vecs[3];
    int   n;
    vecs[0] = '{d: PS2_CMD_SET_LED, par: 1'b1};
    vecs[1] = '{d: 8'h01, par: 1'b0};
    vecs[2] = '{d: 8'h00, par: 1'b1};

    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1;
    rx_byte = 8'h00; rx_par = 1'b0; rx_stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_ok", ack_ok, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Acknowledged frames with hand-computed parity.
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].par, 1'b1, 1'b0, 1'b1, 1'b0);
      device(11, 1'b1);
      wait_ready();
    end
    repeat (5) @(negedge clk);
    chk("ack_ok_hold", ack_ok, 1);

    // Device leaves data high on edge 11.
    send(PS2_CMD_RESET, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    device(11, 1'b0);
    wait_ready();

    // Device never clocks: watchdog fires TO cycles after the clock is released.
    send(PS2_CMD_ENABLE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    device(0, 1'b0);
    n = 0;
    while (!err && n < TO + 100) begin n++; @(negedge clk); end
    chk("timeout_cycles", n, TO);
    @(negedge clk);
    chk("timeout_done_low", done, 0);

    // Reset after edge 5 abandons the frame; the next frame is unaffected.
    send(PS2_CMD_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    device(5, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_clk_oe", ps2_clk_oe, 0);
    chk("midrst_data_oe", ps2_data_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_ready", tx_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    send(PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    device(11, 1'b1);
    wait_ready();

    // tx_valid held across a frame: second byte goes in the cycle after done.
    send(PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tx_data = PS2_CMD_SET_LED;
    exp_q.push_back('{data: PS2_CMD_SET_LED, par: 1'b1, ack: 1'b1, is_err: 1'b0});
    device(11, 1'b1);
    n = 0;
    while (!done && n < 200) begin n++; @(negedge clk); end
    chk("b2b_done_seen", done, 1);
    @(negedge clk);
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_gap_ready", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_second_busy", busy, 1);
    chk("b2b_second_clk_oe", ps2_clk_oe, 1);
    device(11, 1'b1);
    wait_ready();

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
